// File: rtl/envelope_detector.sv
// Amplitude envelope follower (instant attack, per-beat exponential release) with a
// SILENT/ATTACK/SUSTAIN/DECAY note classifier, note strobes and note length in beats.
module envelope_detector #(
   parameter int          BEAT_DIV      = 4,
   parameter int          RELEASE_SHIFT = 3,
   parameter logic [15:0] ON_THRESH     = 16'd1024,
   parameter logic [15:0] OFF_THRESH    = 16'd256,
   parameter int          HOLDOFF_BEATS = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic signed [15:0] sample,
   input  logic               sample_valid,
   output logic [15:0]        envelope,
   output logic               envelope_valid,
   output logic [1:0]         phase,
   output logic               note_on,
   output logic               note_off,
   output logic [13:0]        note_length
);
   localparam int CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
   localparam int RW = $clog2(HOLDOFF_BEATS + 1);

   typedef enum logic [1:0] {SILENT, ATTACK, SUSTAIN, DECAY} phase_t;

   phase_t        state, state_nxt;
   logic [CW-1:0] beat_cnt;
   logic [14:0]   env, env_nxt, peak, peak_max, rel_d, abs_val;
   logic [13:0]   len_cnt, len_inc;
   logic [RW-1:0] run_cnt, run_nxt;
   logic          rose, tick, inc, on_nxt, off_nxt;

   // Lower 15 bits of the negation are exact for every negative value except -32768.
   always_comb begin
      if (!sample[15])                abs_val = sample[14:0];
      else if (sample == 16'sh8000)   abs_val = 15'h7FFF;
      else                            abs_val = ~sample[14:0] + 15'd1;
   end

   assign tick     = sample_valid && (beat_cnt == CW'(BEAT_DIV - 1));
   assign inc      = abs_val > env;
   assign rel_d    = env >> RELEASE_SHIFT;
   assign peak_max = (env_nxt > peak) ? env_nxt : peak;
   assign len_inc  = (tick && state != SILENT && len_cnt != 14'h3FFF) ? len_cnt + 14'd1 : len_cnt;

   always_comb begin
      env_nxt = env;
      if (inc)                    env_nxt = abs_val;
      else if (tick && env != 0)  env_nxt = env - ((rel_d == 0) ? 15'd1 : rel_d);
   end

   always_comb begin
      run_nxt = run_cnt;
      if (tick) begin
         if ({1'b0, env_nxt} >= OFF_THRESH)      run_nxt = '0;
         else if (run_cnt != RW'(HOLDOFF_BEATS)) run_nxt = run_cnt + RW'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      on_nxt    = 1'b0;
      off_nxt   = 1'b0;
      if (sample_valid) begin
         case (state)
            SILENT: if ({1'b0, env_nxt} >= ON_THRESH) begin
               state_nxt = ATTACK;
               on_nxt    = 1'b1;
            end
            // Stay in ATTACK while the level keeps climbing between beat ticks.
            ATTACK: if (tick && !(rose || inc)) state_nxt = SUSTAIN;
            SUSTAIN: if (env_nxt < peak_max - (peak_max >> 2)) state_nxt = DECAY;
            DECAY: begin
               if (inc && {1'b0, env_nxt} >= ON_THRESH) begin
                  state_nxt = ATTACK;
                  on_nxt    = 1'b1;
                  off_nxt   = 1'b1;
               end else if (tick && run_nxt == RW'(HOLDOFF_BEATS)) begin
                  state_nxt = SILENT;
                  off_nxt   = 1'b1;
               end
            end
            default: state_nxt = SILENT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= SILENT;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         beat_cnt       <= '0;
         env            <= '0;
         peak           <= '0;
         rose           <= 1'b0;
         run_cnt        <= '0;
         len_cnt        <= '0;
         note_length    <= '0;
         envelope_valid <= 1'b0;
         note_on        <= 1'b0;
         note_off       <= 1'b0;
      end else begin
         envelope_valid <= sample_valid;
         note_on        <= on_nxt;
         note_off       <= off_nxt;
         if (sample_valid) begin
            beat_cnt <= tick ? '0 : beat_cnt + CW'(1);
            env      <= env_nxt;
            peak     <= on_nxt ? env_nxt : peak_max;
            rose     <= tick ? 1'b0 : (rose | inc);
            run_cnt  <= on_nxt ? '0 : run_nxt;
            len_cnt  <= on_nxt ? '0 : len_inc;
            if (off_nxt) note_length <= len_inc;
         end
      end
   end

   assign envelope = {1'b0, env};
   assign phase    = state;
endmodule
